lc4_mem_arbiter: RTL and testbench
==================================

LC4_MEM_ARBITER -- requirements
Module: lc4_mem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 8, memory read latency in cycles from address issue to valid mem_rdata; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: gwe  input  1  global write enable; state advances only in cycles where gwe=1.
REQ-005 Port: i_req  input  1  insn-cache refill request; held until i_gnt.
REQ-006 Port: i_addr  input  16  refill address.
REQ-007 Port: i_gnt  output  1  one-cycle grant to insn requester.
REQ-008 Port: i_rvalid  output  1  one-cycle refill data valid.
REQ-009 Port: i_rdata  output  16  refill data; 16'h0 when i_rvalid=0.
REQ-010 Port: d_req  input  1  data-port request; held until d_gnt.
REQ-011 Port: d_we  input  1  1=write, 0=read; sampled with d_req.
REQ-012 Port: d_addr  input  16  data address.
REQ-013 Port: d_wdata  input  16  write data.
REQ-014 Port: d_gnt  output  1  one-cycle grant to data requester.
REQ-015 Port: d_rvalid  output  1  one-cycle read data or write acknowledge.
REQ-016 Port: d_rdata  output  16  read data; 16'h0 on write ack or when d_rvalid=0.
REQ-017 Port: mem_addr  output  16  shared memory address; 16'h0 when idle.
REQ-018 Port: mem_we  output  1  memory write strobe.
REQ-019 Port: mem_wdata  output  16  memory write data; 16'h0 when mem_we=0.
REQ-020 Port: mem_rdata  input  16  memory read data, valid MEM_LAT cycles after issue.

Function
REQ-021 FSM states IDLE and BUSY; one transaction outstanding at most.
REQ-022 IDLE, gwe=1, any req: winner's gnt asserted combinationally that cycle; addr/we/wdata/owner latched; next state BUSY, counter=0.
REQ-023 No grant in BUSY or when gwe=0; requesters keep req asserted.
REQ-024 BUSY: mem_addr driven from latched address every cycle; mem_we=1 only in first BUSY cycle of a write.
REQ-025 Counter width 4 bits; increments each gwe=1 BUSY cycle; at count MEM_LAT-1 owner's rvalid=1 and rdata=mem_rdata (reads) for that cycle, next state IDLE.
REQ-026 Latency: grant in cycle T (gwe=1 throughout) -> rvalid in cycle T+MEM_LAT; next grant no earlier than T+MEM_LAT+1.
REQ-027 Write: d_rvalid pulses at same latency as read, d_rdata=16'h0.
REQ-028 Simultaneous i_req and d_req: winner per REQ-033/034; loser granted in next IDLE cycle if still requesting.
REQ-029 gwe=0 in BUSY: counter, state, outputs frozen; rvalid deasserted that cycle and reasserted when gwe returns.
REQ-030 Never both gnt, never both rvalid in one cycle.

Reset
REQ-031 rst=1 at clock edge: state IDLE, counter 0, latched registers 0, RR pointer to data; overrides gwe.
REQ-032 Reset during BUSY aborts transaction: no rvalid issued, mem_we=0, all outputs 0 from next cycle.

Configuration
REQ-033 Macro LC4_MEM_ARB_RR_EN undefined: fixed priority, data over insn.
REQ-034 LC4_MEM_ARB_RR_EN defined: round-robin; on contention, pointer requester wins, pointer moves to the other requester after every grant; sole requester always granted.

Structure
REQ-035 Package lc4_mem_pkg: state enum (IDLE, BUSY), owner enum (OWN_I, OWN_D), MEM_LAT default constant.
REQ-036 Sub-module lc4_mem_lat_ctr: latency counter with gwe-qualified increment, clear and terminal-count output.

Verification
REQ-037 i_req=1, i_addr=16'h0123, mem returns 16'hBEEF -> i_gnt at T, mem_addr=16'h0123 for 8 cycles, i_rvalid and i_rdata=16'hBEEF at T+8.
REQ-038 i_req and d_req together, fixed priority -> d_gnt at T, d_rvalid at T+8, i_gnt at T+9, i_rvalid at T+17.
REQ-039 LC4_MEM_ARB_RR_EN, both continuously requesting -> grants alternate D,I,D,I at T, T+9, T+18, T+27.
REQ-040 d_we=1, d_addr=16'h4000, d_wdata=16'h00AA -> mem_we=1 with mem_wdata=16'h00AA only in cycle T+1, d_rvalid at T+8, d_rdata=16'h0.
REQ-041 rst asserted at T+4 of a read -> no rvalid, state IDLE, mem_addr=16'h0 at T+5; gwe held 0 for 3 BUSY cycles -> rvalid delayed to T+11.

Source files
------------

// File: rtl/lc4_mem_pkg.sv
// Shared types and constants for the LC4 memory arbiter.
// Optional round-robin arbitration is selected by the LC4_MEM_ARB_RR_EN macro.
package lc4_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int MEM_LAT_DEFAULT = 8;

endpackage

// File: rtl/lc4_mem_lat_ctr.sv
// Latency counter for the memory arbiter: clears on grant, counts gwe-qualified
// busy cycles and flags the cycle in which read data is returned.
module lc4_mem_lat_ctr
  import lc4_mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       tc
);

  localparam logic [3:0] TC_VAL = 4'(MEM_LAT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/lc4_mem_arbiter.sv
// Two-port (insn refill / data) arbiter onto a single fixed-latency memory.
// Define LC4_MEM_ARB_RR_EN for round-robin; default is data-over-insn priority.
//
// state | meaning
// IDLE  | no transaction outstanding; grant on gwe when any request is present
// BUSY  | one transaction in flight; waits MEM_LAT gwe cycles for the result
module lc4_mem_arbiter
  import lc4_mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;

  logic        ctr_clr;
  logic        ctr_inc;
  logic [3:0]  ctr_cnt;
  logic        ctr_tc;
  logic        d_prio;
  logic        d_win;

`ifdef LC4_MEM_ARB_RR_EN
  owner_e ptr_q, ptr_d;

  // Pointer hands priority to the other requester after every grant.
  always_comb begin
    ptr_d = ptr_q;
    if (d_gnt) begin
      ptr_d = OWN_I;
    end else if (i_gnt) begin
      ptr_d = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= OWN_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign d_prio = (ptr_q == OWN_D);
`else
  assign d_prio = 1'b1;
`endif

  assign d_win   = d_req && (!i_req || d_prio);
  assign ctr_inc = (state_q == BUSY) && gwe;

  lc4_mem_lat_ctr #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .inc (ctr_inc),
    .cnt (ctr_cnt),
    .tc  (ctr_tc)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    ctr_clr  = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Grants are suppressed under reset so nothing is handed out that won't be latched.
        if (gwe && !rst && (i_req || d_req)) begin
          state_d = BUSY;
          ctr_clr = 1'b1;
          if (d_win) begin
            d_gnt   = 1'b1;
            owner_d = OWN_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            i_gnt   = 1'b1;
            owner_d = OWN_I;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = 16'h0;
          end
        end
      end
      BUSY: begin
        if (gwe && !rst && ctr_tc) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
          end else begin
            i_rvalid = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= 16'h0;
      we_q    <= 1'b0;
      wdata_q <= 16'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Counter is cleared on grant, so count 0 in BUSY marks the first busy cycle.
  assign mem_addr  = (state_q == BUSY) ? addr_q : 16'h0;
  assign mem_we    = (state_q == BUSY) && we_q && (ctr_cnt == 4'd0);
  assign mem_wdata = mem_we ? wdata_q : 16'h0;
  assign i_rdata   = i_rvalid ? mem_rdata : 16'h0;
  assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : 16'h0;

endmodule

// File: tb/tb_lc4_mem_arbiter.sv
// Scoreboard bench for lc4_mem_arbiter (MEM_LAT = 8); expected grant and
// rvalid cycles are queued as stimulus is applied. Honours LC4_MEM_ARB_RR_EN.
module tb_lc4_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, gwe;
  logic        i_req, i_gnt, i_rvalid;
  logic [15:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    bit          is_d;
    logic [15:0] data;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rv_q[$];

  lc4_mem_arbiter #(.MEM_LAT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .gwe       (gwe),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a == 16'h0123) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_i(input logic [15:0] a);
    bit got = 0;
    i_req  = 1'b1;
    i_addr = a;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (i_gnt === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("i_req_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic drive_d(input logic [15:0] a, input logic we, input logic [15:0] wd);
    bit got = 0;
    d_req   = 1'b1;
    d_addr  = a;
    d_we    = we;
    d_wdata = wd;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("d_req_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  // Output monitor: matches every grant and rvalid against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    chk("gnt_excl", 32'(i_gnt & d_gnt), 32'd0);
    chk("rv_excl", 32'(i_rvalid & d_rvalid), 32'd0);
    if (i_rvalid !== 1'b1) chk("i_rdata_idle", 32'(i_rdata), 32'd0);
    if (d_rvalid !== 1'b1) chk("d_rdata_idle", 32'(d_rdata), 32'd0);
    if (mem_we !== 1'b1) chk("wdata_idle", 32'(mem_wdata), 32'd0);
    if (i_gnt === 1'b1 || d_gnt === 1'b1) begin
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", {30'd0, d_gnt, i_gnt}, 32'd0);
      end else begin
        e = gnt_q.pop_front();
        chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
        chk("gnt_who", 32'(d_gnt), 32'(e.is_d));
      end
    end
    if (i_rvalid === 1'b1 || d_rvalid === 1'b1) begin
      if (rv_q.size() == 0) begin
        chk("rv_unexpected", {30'd0, d_rvalid, i_rvalid}, 32'd0);
      end else begin
        e = rv_q.pop_front();
        chk("rv_cycle", 32'(cyc), 32'(e.cyc));
        chk("rv_who", 32'(d_rvalid), 32'(e.is_d));
        chk("rv_data", 32'(e.is_d ? d_rdata : i_rdata), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit rr;
`ifdef LC4_MEM_ARB_RR_EN
    rr = 1;
`else
    rr = 0;
`endif
    rst = 1'b1; gwe = 1'b1;
    i_req = 1'b0; i_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    wait_until(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    wait_until(5);

    // Single insn refill
    t = cyc;
    gnt_q.push_back('{t, 1'b0, 16'h0});
    rv_q.push_back('{t + 8, 1'b0, 16'hBEEF});
    fork
      drive_i(16'h0123);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk($sformatf("rd_mem_addr%0d", k), 32'(mem_addr),
            (k >= 1 && k <= 8) ? 32'h0123 : 32'h0);
        chk($sformatf("rd_mem_we%0d", k), 32'(mem_we), 32'd0);
      end
    join
    wait_until(t + 10);

    // Contention: data wins first, insn follows after the data transaction
    t = cyc;
    gnt_q.push_back('{t, 1'b1, 16'h0});
    rv_q.push_back('{t + 8, 1'b1, mem_f(16'h2222)});
    gnt_q.push_back('{t + 9, 1'b0, 16'h0});
    rv_q.push_back('{t + 17, 1'b0, mem_f(16'h1111)});
    fork
      drive_d(16'h2222, 1'b0, 16'h0);
      drive_i(16'h1111);
    join
    wait_until(t + 19);

    // Data write
    t = cyc;
    gnt_q.push_back('{t, 1'b1, 16'h0});
    rv_q.push_back('{t + 8, 1'b1, 16'h0});
    fork
      drive_d(16'h4000, 1'b1, 16'h00AA);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk($sformatf("wr_mem_we%0d", k), 32'(mem_we), (k == 1) ? 32'd1 : 32'd0);
        chk($sformatf("wr_mem_wdata%0d", k), 32'(mem_wdata), (k == 1) ? 32'h00AA : 32'h0);
      end
    join
    wait_until(t + 10);

    // Reset in the middle of a read: grant only, never an rvalid
    t = cyc;
    gnt_q.push_back('{t, 1'b0, 16'h0});
    fork
      drive_i(16'h3333);
      begin
        wait_until(t + 4);
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_mem_addr", 32'(mem_addr), 32'h3333);
        wait_until(t + 5);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("post_rst_mem_we", 32'(mem_we), 32'd0);
        chk("post_rst_rvalid", 32'(i_rvalid), 32'd0);
      end
    join
    wait_until(t + 14);

    // gwe low for three busy cycles stretches latency by three
    t = cyc;
    gnt_q.push_back('{t, 1'b1, 16'h0});
    rv_q.push_back('{t + 11, 1'b1, mem_f(16'h0777)});
    fork
      drive_d(16'h0777, 1'b0, 16'h0);
      begin
        wait_until(t + 2);
        gwe = 1'b0;
        @(negedge clk);
        chk("stall_mem_addr", 32'(mem_addr), 32'h0777);
        wait_until(t + 5);
        gwe = 1'b1;
      end
    join
    wait_until(t + 13);

    // gwe low in IDLE holds off the grant
    t = cyc;
    gwe = 1'b0;
    gnt_q.push_back('{t + 2, 1'b0, 16'h0});
    rv_q.push_back('{t + 10, 1'b0, mem_f(16'h0055)});
    fork
      drive_i(16'h0055);
      begin
        wait_until(t + 2);
        gwe = 1'b1;
      end
    join
    wait_until(t + 12);

    // Both requesting continuously: alternate under RR, data starves insn otherwise
    t = cyc;
    i_req = 1'b1; i_addr = 16'h1A1A;
    d_req = 1'b1; d_addr = 16'h2B2B; d_we = 1'b0; d_wdata = 16'h0;
    for (int g = 0; g < 4; g++) begin
      bit who_d;
      who_d = rr ? (g % 2 == 0) : 1'b1;
      gnt_q.push_back('{t + 9 * g, who_d, 16'h0});
      rv_q.push_back('{t + 9 * g + 8, who_d, who_d ? mem_f(16'h2B2B) : mem_f(16'h1A1A)});
    end
    wait_until(t + 28);
    i_req = 1'b0;
    d_req = 1'b0;
    wait_until(t + 40);

    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    chk("rv_q_empty", 32'(rv_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
